dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder end of the data-memory port driven by the RV32I core's load/store path.
- Accepts one request at a time over a valid/ready handshake and holds a word-organised storage array.
- Performs RV32I sized stores (SB/SH/SW) and loads (LB/LH/LW/LBU/LHU) with byte-lane alignment and sign/zero extension.
- Returns each result over a response valid/ready handshake after a programmable wait-state count.

Parameters:
- DATA_WIDTH, 32, data and address width; fixed at 32 for RV32I.
- DEPTH_WORDS, 1024, number of 32-bit words in storage; power of two.
- WAIT_CYCLES, 1, extra cycles between request accept and response; 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (rs2).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  32  aligned and extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal-size request.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait counter=0.
  - Storage contents are not reset.
- Ready after reset: req_ready is registered and rises on the first clk edge after rst_n deasserts.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. A request is accepted on the edge where req_valid&&req_ready; req_ready drops the cycle after accept.
  - Accept with error: go to RESP; no storage access.
  - Accept without error: with WAIT_CYCLES=0 perform the access at the accept edge and go to RESP; otherwise load the counter with WAIT_CYCLES-1 and go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter is 0, perform the access on that edge and go to RESP.
  - RESP: rsp_valid=1 and rsp_rdata/rsp_err held stable until rsp_valid&&rsp_ready. On that edge rsp_valid drops, the state returns to IDLE and req_ready rises.
- Latency: rsp_valid asserts WAIT_CYCLES+1 cycles after the accept edge; errors assert after 1 cycle. Back-to-back throughput is one request per WAIT_CYCLES+3 cycles minimum.
- Request capture: all request fields are registered at accept. Input changes after accept are ignored.
- Error conditions:
  - req_size not in the legal set; stores with size 100/101 are also errors.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - addr[31:2] >= DEPTH_WORDS.
- Store byte enables, with lane=addr[1:0]:
  - SB writes byte lane `lane` with wdata[7:0].
  - SH writes lanes {lane+1,lane} with wdata[15:0].
  - SW writes all 4 lanes.
  - Unselected lanes are unchanged.
- Load data: the word is read, shifted right by 8*lane, then sign-extended (B, H) or zero-extended (BU, HU).
- Store followed by a load to the same address always returns the new data, since the write is committed before the next accept.
- rsp_ready may be held high before rsp_valid; the response completes on its first valid cycle.
- Reset mid-operation: the pending transaction is dropped. Any write not yet committed is lost, and no response is produced.

Optional Feature:
- Macro DMEM_ERR_CNT_EN.
- When defined:
  - Adds output port err_cnt, 16 bits, reset 0.
  - Increments on every accepted request that sets rsp_err.
  - Saturates at 16'hFFFF.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package dmem_pkg contains:
  - mem_size_e enum: SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101.
  - dmem_state_e enum: IDLE, WAIT, RESP.
  - Constant XLEN=32.
- Sub-module dmem_lane_align (combinational) computes:
  - byte-enable mask and shifted write word for stores;
  - shifted, extended read word for loads.
- The FSM, counter and storage stay in dmem_responder.

Test Plan:
- Reset handling: hold rst_n=0 for 3 cycles with req_valid=1. Required: req_ready=0 and rsp_valid=0 throughout; req_ready=1 one edge after release.
- Word round-trip: with WAIT_CYCLES=2, SW addr 0x10 data 0xDEADBEEF, then LW 0x10. Required: rsp_valid 3 cycles after each accept; load rdata=0xDEADBEEF, err=0.
- Byte/half lanes: SW 0x20 data 0, SB 0x21 data 0x80, SH 0x22 data 0xFFFE.
  - LW 0x20 returns 0xFFFE8000.
  - LB 0x21 returns 0xFFFFFF80.
  - LBU 0x21 returns 0x00000080.
  - LHU 0x22 returns 0x0000FFFE.
- Errors: LW 0x13, SH 0x05, LW 0x1000 (DEPTH 1024), req_size=011.
  - Each returns rsp_err=1 and rdata=0 one cycle after accept; memory is unchanged.
  - With DMEM_ERR_CNT_EN, err_cnt=4.
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP while changing req_*. Required: rsp_rdata/rsp_err stable, req_ready=0, no new accept.
- Mid-operation reset: assert rst_n low during WAIT of SW 0x40 data 0x12345678 (prior value 0x0). Required: no response; a later LW 0x40 returns 0x0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states, request record.
package dmem_pkg;

   localparam int XLEN      = 32;
   localparam int NUM_LANES = XLEN / 8;

   typedef enum logic [2:0] {
      SZ_B  = 3'b000,
      SZ_H  = 3'b001,
      SZ_W  = 3'b010,
      SZ_BU = 3'b100,
      SZ_HU = 3'b101
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_e;

   typedef struct packed {
      logic            we;
      logic [2:0]      size;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } dmem_req_t;

   // Unsigned sizes only make sense for loads.
   function automatic logic size_legal(input logic [2:0] sz, input logic we);
      case (sz)
         SZ_B, SZ_H, SZ_W: size_legal = 1'b1;
         SZ_BU, SZ_HU:     size_legal = !we;
         default:          size_legal = 1'b0;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] sz, input logic [1:0] lane);
      misaligned = ((sz == SZ_H || sz == SZ_HU) && lane[0]) ||
                   (sz == SZ_W && lane != 2'b00);
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write word, load shift and extension.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]           size_i,
   input  logic [1:0]           lane_i,
   input  logic [XLEN-1:0]      wdata_i,
   input  logic [XLEN-1:0]      rword_i,
   output logic [NUM_LANES-1:0] be_o,
   output logic [XLEN-1:0]      wword_o,
   output logic [XLEN-1:0]      rdata_o
);

   logic [XLEN-1:0] shifted;

   assign shifted = rword_i >> {lane_i, 3'b000};

   // Store data is replicated across lanes so the byte enables alone pick the target bytes.
   always_comb begin
      be_o    = '0;
      wword_o = wdata_i;
      rdata_o = '0;
      case (size_i)
         SZ_B: begin
            be_o    = 4'b0001 << lane_i;
            wword_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{shifted[7]}}, shifted[7:0]};
         end
         SZ_H: begin
            be_o    = 4'b0011 << lane_i;
            wword_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{shifted[15]}}, shifted[15:0]};
         end
         SZ_W: begin
            be_o    = 4'b1111;
            rdata_o = shifted;
         end
         SZ_BU:   rdata_o = {24'd0, shifted[7:0]};
         SZ_HU:   rdata_o = {16'd0, shifted[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store path: one request at a time, programmable wait states.
// Optional saturating error counter on port err_cnt when DMEM_ERR_CNT_EN is defined.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_size,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
`ifdef DMEM_ERR_CNT_EN
   ,
   output logic [15:0]           err_cnt
`endif
);

   localparam int         AW      = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   dmem_state_e     state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   dmem_req_t       req_q, req_d, req_in, cur;
   logic            req_ready_q, req_ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
   logic            rsp_err_q, rsp_err_d;

   logic                 accept, cur_err, do_access, mem_we;
   logic [AW-1:0]        idx;
   logic [NUM_LANES-1:0] be;
   logic [XLEN-1:0]      wword, ld_data, rword;
   logic [XLEN-1:0]      mem [DEPTH_WORDS];

   assign req_in = {req_we, req_size, req_addr, req_wdata};
   assign accept = (state_q == IDLE) && req_valid && req_ready_q;

   // In IDLE the access (zero-wait case) works straight off the inputs; later from the captured copy.
   assign cur     = (state_q == IDLE) ? req_in : req_q;
   assign idx     = cur.addr[AW+1:2];
   assign cur_err = !size_legal(cur.size, cur.we) || misaligned(cur.size, cur.addr[1:0]) ||
                    (|cur.addr[XLEN-1:AW+2]);
   assign rword   = mem[idx];

   dmem_lane_align u_align (
      .size_i  (cur.size),
      .lane_i  (cur.addr[1:0]),
      .wdata_i (cur.wdata),
      .rword_i (rword),
      .be_o    (be),
      .wword_o (wword),
      .rdata_o (ld_data)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      do_access   = 1'b0;
      mem_we      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               req_d = req_in;
               if (cur_err) begin
                  state_d     = RESP;
                  rsp_rdata_d = '0;
                  rsp_err_d   = 1'b1;
               end else if (WAIT_CYCLES == 0) begin
                  do_access = 1'b1;
               end else begin
                  cnt_d   = WAIT_LD;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) do_access = 1'b1;
            else               cnt_d     = cnt_q - 4'd1;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (do_access) begin
         mem_we      = cur.we;
         rsp_rdata_d = cur.we ? '0 : ld_data;
         rsp_err_d   = 1'b0;
         state_d     = RESP;
      end
      rsp_valid_d = (state_d == RESP);
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_LANES; i++) begin
         if (mem_we && be[i]) mem[idx][i*8 +: 8] <= wword[i*8 +: 8];
      end
   end

`ifdef DMEM_ERR_CNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                         err_cnt_q <= '0;
      else if (accept && cur_err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
   end

   assign err_cnt = err_cnt_q;
`endif

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table through a scoreboard plus reset/backpressure sequences.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int WC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
   logic [2:0]  req_size = 3'b000;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
`ifdef DMEM_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(WC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
`ifdef DMEM_ERR_CNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   typedef struct {
      logic        we;
      logic [2:0]  sz;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   exp_t sbq[$];
   vec_t vt[20];
   int   checks = 0, errors = 0, n_err_exp = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", nm);
   endtask

   // Drive a request at a negedge; returns once the accept edge has passed (we are at the next negedge).
   task automatic send(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       output logic ok);
      ok = 1'b0;
      req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
      for (int n = 0; n < 50 && !ok; n++) begin
         ok = req_ready;
         @(negedge clk);
      end
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_size  = 3'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
   endtask

   task automatic xact(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int hold);
      exp_t e;
      int   n;
      logic ok;
      e.rdata = er; e.err = ee; e.lat = ee ? 1 : WC + 1;
      sbq.push_back(e);
      if (ee) n_err_exp++;
      @(negedge clk);
      rsp_ready = (hold == 0);
      send(we, sz, a, wd, ok);
      if (!ok) begin
         timeout("accept");
         void'(sbq.pop_front());
         return;
      end
      n = 1;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) begin
         timeout("response");
         void'(sbq.pop_front());
         return;
      end
      e = sbq.pop_front();
      for (int k = 0; k < hold; k++) begin
         req_valid = 1'b1; req_we = 1'($urandom); req_addr = $urandom & 32'hFFC; req_wdata = $urandom;
         req_size = 3'b010;
         @(negedge clk);
         chk("bp_rdata", rsp_rdata, e.rdata);
         chk("bp_err", rsp_err, e.err);
         chk("bp_valid", rsp_valid, 1'b1);
         chk("bp_req_ready", req_ready, 1'b0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      chk("rdata", rsp_rdata, e.rdata);
      chk("err", rsp_err, e.err);
      chk("latency", n, e.lat);
      @(negedge clk);
      chk("rsp_drop", rsp_valid, 1'b0);
   endtask

   initial begin
      logic ok;
      vt[0]  = '{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
      vt[1]  = '{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b1, 3'b010, 32'h20,   32'h0,        32'h0,        1'b0};
      vt[3]  = '{1'b1, 3'b000, 32'h21,   32'hAABBCC80, 32'h0,        1'b0};
      vt[4]  = '{1'b1, 3'b001, 32'h22,   32'h1234FFFE, 32'h0,        1'b0};
      vt[5]  = '{1'b0, 3'b010, 32'h20,   32'h0,        32'hFFFE8000, 1'b0};
      vt[6]  = '{1'b0, 3'b000, 32'h21,   32'h0,        32'hFFFFFF80, 1'b0};
      vt[7]  = '{1'b0, 3'b100, 32'h21,   32'h0,        32'h00000080, 1'b0};
      vt[8]  = '{1'b0, 3'b101, 32'h22,   32'h0,        32'h0000FFFE, 1'b0};
      vt[9]  = '{1'b0, 3'b001, 32'h22,   32'h0,        32'hFFFFFFFE, 1'b0};
      vt[10] = '{1'b1, 3'b010, 32'h04,   32'hA5A5A5A5, 32'h0,        1'b0};
      vt[11] = '{1'b0, 3'b010, 32'h13,   32'h0,        32'h0,        1'b1};
      vt[12] = '{1'b1, 3'b001, 32'h05,   32'h00001234, 32'h0,        1'b1};
      vt[13] = '{1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1};
      vt[14] = '{1'b0, 3'b011, 32'h00,   32'h0,        32'h0,        1'b1};
      vt[15] = '{1'b1, 3'b100, 32'h04,   32'h00000011, 32'h0,        1'b1};
      vt[16] = '{1'b0, 3'b010, 32'h04,   32'h0,        32'hA5A5A5A5, 1'b0};
      vt[17] = '{1'b0, 3'b000, 32'h23,   32'h0,        32'hFFFFFFFF, 1'b0};
      vt[18] = '{1'b1, 3'b010, 32'hFFC,  32'h0BADF00D, 32'h0,        1'b0};
      vt[19] = '{1'b0, 3'b010, 32'hFFC,  32'h0,        32'h0BADF00D, 1'b0};

      // Reset held with a pending request.
      #1 rst_n = 1'b0;
      req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_req_ready", req_ready, 1'b0);
         chk("rst_rsp_valid", rsp_valid, 1'b0);
      end
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", rsp_err, 1'b0);
      rst_n = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", req_ready, 1'b1);

      for (int i = 0; i < 20; i++)
         xact(vt[i].we, vt[i].sz, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].err, 0);

`ifdef DMEM_ERR_CNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(n_err_exp));
`endif

      // Response held under backpressure while the request inputs wiggle.
      xact(1'b0, 3'b010, 32'h20, 32'h0, 32'hFFFE8000, 1'b0, 5);
      xact(1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, 3);

      // Reset during WAIT drops the store.
      xact(1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0, 0);
      @(negedge clk);
      rsp_ready = 1'b1;
      send(1'b1, 3'b010, 32'h40, 32'h12345678, ok);
      if (!ok) timeout("mid_rst_accept");
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("mid_rst_valid", rsp_valid, 1'b0);
         chk("mid_rst_ready", req_ready, 1'b0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_no_rsp", rsp_valid, 1'b0);
      end
      chk("post_rst_ready", req_ready, 1'b1);
      xact(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
